// File: rtl/riscv_div_unit_if.sv
// -----------------------------------------------------------------------------
// riscv_div_unit_if
// Request/response bundle between the EX stage and the iterative divider.
//   start    : request pulse, only honoured while the divider is idle
//   flush    : synchronous abort from the hazard unit
//   op       : funct3[1:0] -> 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend : rs1 value, sampled with start
//   divisor  : rs2 value, sampled with start
//   result   : quotient or remainder, registered
//   busy     : high while the divider is not idle (pipeline stall request)
//   done     : one-cycle pulse, result valid
// master = pipeline side, slave = divider side.
// -----------------------------------------------------------------------------
interface riscv_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, flush, op, dividend, divisor,
        input  result, busy, done
    );

    modport slave (
        input  start, flush, op, dividend, divisor,
        output result, busy, done
    );
endinterface

// File: rtl/riscv_div_unit.sv
// -----------------------------------------------------------------------------
// riscv_div_unit
// Radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
// Operands are latched on start; signed ops divide magnitudes and fix the
// signs afterwards. Divide-by-zero and signed overflow are resolved on the
// start edge and skip the iteration entirely.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : riscv_div_unit_if.slave (start/flush/op/operands in,
//           result/busy/done out)
// Latency: done is high WIDTH+2 cycles after the start cycle (normal case),
// or in the cycle right after the start cycle (special cases).
// -----------------------------------------------------------------------------
module riscv_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    riscv_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg, op_next;
    logic [WIDTH-1:0] q_reg, q_next;        // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] div_reg, div_next;    // divisor magnitude
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    // Operand conditioning for the start edge
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             is_ovf;

    // One restoring step; the partial remainder is widened by one bit so a
    // remainder with its MSB set is not lost when shifted left.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.dividend[WIDTH-1];
    assign b_neg     = signed_op & bus.divisor[WIDTH-1];
    assign abs_a     = a_neg ? -bus.dividend : bus.dividend;
    assign abs_b     = b_neg ? -bus.divisor  : bus.divisor;
    assign is_ovf    = signed_op && (bus.dividend == MIN_INT) && (bus.divisor == '1);

    assign shifted   = {rem_reg, q_reg[WIDTH-1]};
    assign diff      = shifted - {1'b0, div_reg};
    assign fits      = (shifted >= {1'b0, div_reg});

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        q_next      = q_reg;
        rem_next    = rem_reg;
        div_next    = div_reg;
        cnt_next    = cnt_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        result_next = result_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_next = bus.op;
                    if (bus.divisor == '0) begin
                        result_next = bus.op[1] ? bus.dividend : '1;
                        state_next  = DONE;
                    end else if (is_ovf) begin
                        result_next = bus.op[1] ? '0 : bus.dividend;
                        state_next  = DONE;
                    end else begin
                        q_next     = abs_a;
                        rem_next   = '0;
                        div_next   = abs_b;
                        neg_q_next = a_neg ^ b_neg;
                        neg_r_next = a_neg;
                        cnt_next   = CW'(WIDTH - 1);
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                q_next   = {q_reg[WIDTH-2:0], fits};
                rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                if (op_reg[1]) begin
                    result_next = neg_r_reg ? -rem_reg : rem_reg;
                end else begin
                    result_next = neg_q_reg ? -q_reg : q_reg;
                end
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort wins over everything, including a pending result load
        if (bus.flush) begin
            state_next  = IDLE;
            result_next = result_reg;
        end
    end

    // busy/done are registered copies of the next state so they carry no
    // combinational path from the inputs.
    assign busy_next = (state_next != IDLE);
    assign done_next = (state_next == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            q_reg      <= '0;
            rem_reg    <= '0;
            div_reg    <= '0;
            cnt_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            q_reg      <= q_next;
            rem_reg    <= rem_next;
            div_reg    <= div_next;
            cnt_reg    <= cnt_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            result_reg <= result_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign bus.result = result_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
endmodule
